// File: rtl/id_ex_stage.sv
// Decode-and-issue stage: field split, operand read with write-back bypass, and the
// ID/EX pipeline register with load-use bubble insertion, flush and downstream stall.
module id_ex_stage #(
  parameter logic [5:0] LOAD_OP = 6'b010111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_stall,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [5:0]  opcode,
  output logic [4:0]  R_type_shamt,
  output logic [20:0] I_type_imm,
  output logic [25:0] J_type_imm,
  output logic [31:0] PC_out,
  output logic [31:0] reg_data1,
  output logic [31:0] reg_data2,
  output logic [2:0]  alu_src,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_is_load
);

  logic [5:0]  dec_op;
  logic [4:0]  rs, rt;
  logic [2:0]  dec_alu;
  logic [4:0]  dec_rd;
  logic        reads_rt;
  logic [31:0] op1, op2;
  logic        hazard;
  logic        load_inst;

  assign dec_op    = if_inst[31:26];
  assign rs        = if_inst[25:21];
  assign rt        = if_inst[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  always_comb begin
    dec_alu  = 3'b100;
    dec_rd   = 5'd0;
    reads_rt = 1'b0;
    case (dec_op[5:3])
      3'b000: begin
        dec_alu  = 3'b000;
        dec_rd   = if_inst[15:11];
        reads_rt = 1'b1;
      end
      3'b001: begin
        dec_alu = 3'b010;
        dec_rd  = if_inst[15:11];
      end
      3'b010: begin
        dec_alu = 3'b001;
        dec_rd  = rt;
      end
      3'b011: dec_alu = 3'b011;
      3'b100: begin
        dec_alu  = 3'b000;
        reads_rt = 1'b1;
      end
      default: dec_alu = 3'b100;
    endcase
  end

  // Register 0 is hardwired to zero, so it is never bypassed.
  assign op1 = (rs == 5'd0) ? 32'd0 : (wb_we && wb_addr == rs) ? wb_data : rf_rdata1;
  assign op2 = (rt == 5'd0) ? 32'd0 : (wb_we && wb_addr == rt) ? wb_data : rf_rdata2;

  assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) && if_valid &&
                  ((ex_rd == rs) || (reads_rt && ex_rd == rt));

  assign id_ready  = flush || (!ex_stall && !hazard);
  assign load_inst = !flush && !ex_stall && !hazard && if_valid;

  // Every path except a stall rewrites ID/EX: either the decoded instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode       <= '0;
      R_type_shamt <= '0;
      I_type_imm   <= '0;
      J_type_imm   <= '0;
      PC_out       <= '0;
      reg_data1    <= '0;
      reg_data2    <= '0;
      alu_src      <= '0;
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_is_load   <= 1'b0;
    end else if (flush || !ex_stall) begin
      if (load_inst) begin
        opcode       <= dec_op;
        R_type_shamt <= if_inst[10:6];
        I_type_imm   <= if_inst[20:0];
        J_type_imm   <= if_inst[25:0];
        PC_out       <= if_pc;
        reg_data1    <= op1;
        reg_data2    <= op2;
        alu_src      <= dec_alu;
        ex_valid     <= 1'b1;
        ex_rd        <= dec_rd;
        ex_is_load   <= (dec_op == LOAD_OP);
      end else begin
        opcode       <= '0;
        R_type_shamt <= '0;
        I_type_imm   <= '0;
        J_type_imm   <= '0;
        PC_out       <= '0;
        reg_data1    <= '0;
        reg_data2    <= '0;
        alu_src      <= '0;
        ex_valid     <= 1'b0;
        ex_rd        <= '0;
        ex_is_load   <= 1'b0;
      end
    end
  end

endmodule
